// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (shift-add-3) with a one-deep load buffer,
// driving a 4-digit multiplexed seven-segment display from an internal scan prescaler.
module bcd_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       signed_mode,
  output logic       busy,
  output logic [6:0] display,
  output logic [3:0] display_en
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [19:0] scratch_reg, scratch_next;
  logic        neg_reg, neg_next;
  logic [2:0]  shift_cnt_reg, shift_cnt_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [7:0]  pend_value_reg, pend_value_next;
  logic        pend_signed_reg, pend_signed_next;
  logic [3:0]  hund_reg, hund_next, tens_reg, tens_next, units_reg, units_next;
  logic        sign_reg, sign_next;

  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    idx_reg, idx_next;
  logic [6:0]    display_reg, display_next;
  logic [3:0]    display_en_reg, display_en_next;
  logic          tick;

  logic [19:0] adjusted;
  logic [7:0]  cap_value;
  logic        cap_signed;
  logic [8:0]  cap_split;

  function automatic logic [8:0] split_magnitude(input logic [7:0] v, input logic s);
    logic [7:0] neg_v;
    neg_v = ~v + 8'd1;
    if (s && v[7]) return {1'b1, neg_v};
    return {1'b0, v};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Add-3 correction on the three BCD nibbles before each shift.
  assign adjusted[7:0] = scratch_reg[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    logic [3:0] nib;
    assign nib = scratch_reg[8 + 4*gi +: 4];
    assign adjusted[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  // A direct load always wins; otherwise the buffered entry is the capture source.
  assign cap_value  = load ? value : pend_value_reg;
  assign cap_signed = load ? signed_mode : pend_signed_reg;
  assign cap_split  = split_magnitude(cap_value, cap_signed);

  assign busy = (state_reg != ST_IDLE);

  always_comb begin
    state_next       = state_reg;
    scratch_next     = scratch_reg;
    neg_next         = neg_reg;
    shift_cnt_next   = shift_cnt_reg;
    pend_valid_next  = pend_valid_reg;
    pend_value_next  = pend_value_reg;
    pend_signed_next = pend_signed_reg;
    hund_next        = hund_reg;
    tens_next        = tens_reg;
    units_next       = units_reg;
    sign_next        = sign_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          neg_next       = cap_split[8];
          scratch_next   = {12'b0, cap_split[7:0]};
          shift_cnt_next = 3'd0;
          state_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_next   = adjusted << 1;
        shift_cnt_next = shift_cnt_reg + 3'd1;
        if (shift_cnt_reg == 3'd7) state_next = ST_COMMIT;
        if (load) begin
          pend_valid_next  = 1'b1;
          pend_value_next  = value;
          pend_signed_next = signed_mode;
        end
      end
      ST_COMMIT: begin
        hund_next  = scratch_reg[19:16];
        tens_next  = scratch_reg[15:12];
        units_next = scratch_reg[11:8];
        sign_next  = neg_reg;
        if (load || pend_valid_reg) begin
          if (!load) pend_valid_next = 1'b0;
          neg_next       = cap_split[8];
          scratch_next   = {12'b0, cap_split[7:0]};
          shift_cnt_next = 3'd0;
          state_next     = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Scanner: outputs are registered from the upcoming index so they move the cycle after the tick.
  assign tick       = (count_reg == CW'(SCAN_DIV - 1));
  assign count_next = tick ? '0 : count_reg + CW'(1);
  assign idx_next   = tick ? idx_reg + 2'd1 : idx_reg;
  assign display_en_next = ~(4'b0001 << idx_next);

  always_comb begin
    display_next = 7'b0000000;
    case (idx_next)
      2'd0: display_next = seg7(units_reg);
      2'd1: if (hund_reg != 4'd0 || tens_reg != 4'd0) display_next = seg7(tens_reg);
      2'd2: if (hund_reg != 4'd0) display_next = seg7(hund_reg);
      2'd3: if (sign_reg) display_next = 7'b0000001;
      default: display_next = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg       <= ST_IDLE;
      scratch_reg     <= '0;
      neg_reg         <= 1'b0;
      shift_cnt_reg   <= '0;
      pend_valid_reg  <= 1'b0;
      pend_value_reg  <= '0;
      pend_signed_reg <= 1'b0;
      hund_reg        <= '0;
      tens_reg        <= '0;
      units_reg       <= '0;
      sign_reg        <= 1'b0;
      count_reg       <= '0;
      idx_reg         <= '0;
      display_reg     <= 7'b1111110;
      display_en_reg  <= 4'b1110;
    end else begin
      state_reg       <= state_next;
      scratch_reg     <= scratch_next;
      neg_reg         <= neg_next;
      shift_cnt_reg   <= shift_cnt_next;
      pend_valid_reg  <= pend_valid_next;
      pend_value_reg  <= pend_value_next;
      pend_signed_reg <= pend_signed_next;
      hund_reg        <= hund_next;
      tens_reg        <= tens_next;
      units_reg       <= units_next;
      sign_reg        <= sign_next;
      count_reg       <= count_next;
      idx_reg         <= idx_next;
      display_reg     <= display_next;
      display_en_reg  <= display_en_next;
    end
  end

  assign display    = display_reg;
  assign display_en = display_en_reg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: cycle-timed behavioural model checked every cycle,
// plus literal frame and busy-length expectations for directed loads.
module tb_bcd_display_driver;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] value = 8'd0;
  logic       busy;
  logic [6:0] display;
  logic [3:0] display_en;

  bcd_display_driver #(.SCAN_DIV(D)) dut (
    .clk(clk), .clear(clear), .value(value), .load(load), .signed_mode(signed_mode),
    .busy(busy), .display(display), .display_en(display_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  bit   m_valid = 0;
  int   cyc = 0, rst_cyc = 0, commit_at = 0;
  bit   m_busy = 0, m_pend = 0;
  logic [7:0] pend_v;
  logic pend_s;
  int   cur_val = 0, shown_val = 0;
  bit   cur_neg = 0, shown_neg = 0;
  logic [3:0] exp_en;
  logic [6:0] exp_disp;

  function automatic int mag_of(input logic [7:0] v, input logic s);
    return (s && v[7]) ? 256 - int'(v) : int'(v);
  endfunction

  function automatic logic [6:0] slot_seg(input int slot, input int v, input bit neg);
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    if (slot == 0) return seg_tab[u];
    if (slot == 1) return (h == 0 && t == 0) ? 7'b0000000 : seg_tab[t];
    if (slot == 2) return (h == 0) ? 7'b0000000 : seg_tab[h];
    return neg ? 7'b0000001 : 7'b0000000;
  endfunction

  task automatic m_start(input logic [7:0] v, input logic s);
    cur_val   = mag_of(v, s);
    cur_neg   = s && v[7];
    commit_at = cyc + 9;
    m_busy    = 1;
  endtask

  always @(posedge clk) begin
    int slot;
    cyc++;
    if (clear) begin
      m_valid = 1; rst_cyc = cyc; m_busy = 0; m_pend = 0;
      shown_val = 0; shown_neg = 0;
      exp_en = 4'b1110; exp_disp = 7'b1111110;
    end else if (m_valid) begin
      slot     = ((cyc - rst_cyc) / D) % 4;
      exp_en   = ~(4'b0001 << slot);
      exp_disp = slot_seg(slot, shown_val, shown_neg);
      if (m_busy && cyc == commit_at) begin
        shown_val = cur_val; shown_neg = cur_neg;
        if (load) m_start(value, signed_mode);
        else if (m_pend) begin m_start(pend_v, pend_s); m_pend = 0; end
        else m_busy = 0;
      end else if (m_busy) begin
        if (load) begin m_pend = 1; pend_v = value; pend_s = signed_mode; end
      end else if (load) begin
        m_start(value, signed_mode);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("display_en", 32'(display_en), 32'(exp_en));
      check("display", 32'(display), 32'(exp_disp));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [6:0] frame [4];

  task automatic do_load(input logic [7:0] v, input logic s);
    value = v; signed_mode = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load value=%02h signed=%0d at cycle %0d", v, s, cyc);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic capture_frame();
    for (int k = 0; k < 4; k++) frame[k] = 7'bx;
    repeat (4 * D) begin
      @(negedge clk);
      case (display_en)
        4'b1110: frame[0] = display;
        4'b1101: frame[1] = display;
        4'b1011: frame[2] = display;
        4'b0111: frame[3] = display;
        default: ;
      endcase
    end
    $display("frame sign=%b hund=%b tens=%b units=%b", frame[3], frame[2], frame[1], frame[0]);
  endtask

  task automatic check_frame(input string name, input logic [6:0] u, input logic [6:0] t,
                             input logic [6:0] h, input logic [6:0] s);
    check({name, "_units"}, 32'(frame[0]), 32'(u));
    check({name, "_tens"},  32'(frame[1]), 32'(t));
    check({name, "_hund"},  32'(frame[2]), 32'(h));
    check({name, "_sign"},  32'(frame[3]), 32'(s));
  endtask

  task automatic run_conv(input string name, input logic [7:0] v, input logic s,
                          input logic [6:0] u, input logic [6:0] t,
                          input logic [6:0] h, input logic [6:0] sg);
    int n;
    do_load(v, s);
    count_busy(n);
    check({name, "_busy_len"}, 32'(n), 32'd9);
    @(negedge clk);
    capture_frame();
    check_frame(name, u, t, h, sg);
  endtask

  initial begin
    int n;
    logic [3:0] e;
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_display_en", 32'(display_en), 32'(4'b1110));
    check("rst_display", 32'(display), 32'(7'b1111110));
    check("rst_busy", 32'(busy), 32'd0);
    clear = 1'b0;
    $display("reset released at cycle %0d", cyc);
    for (int i = 0; i < 16; i++) begin
      e = ~(4'b0001 << (i / 4));
      check("scan_step", 32'(display_en), 32'(e));
      @(negedge clk);
    end

    run_conv("u255", 8'hFF, 1'b0, 7'b1011011, 7'b1011011, 7'b1101101, 7'b0000000);
    run_conv("s128", 8'h80, 1'b1, 7'b1111111, 7'b1101101, 7'b0110000, 7'b0000001);
    run_conv("sm1",  8'hFF, 1'b1, 7'b0110000, 7'b0000000, 7'b0000000, 7'b0000001);
    run_conv("u7",   8'h07, 1'b0, 7'b1110000, 7'b0000000, 7'b0000000, 7'b0000000);
    run_conv("u100", 8'h64, 1'b0, 7'b1111110, 7'b1111110, 7'b0110000, 7'b0000000);

    // Buffering: 12 at E, 34 at E+2, 56 at E+4; busy runs through E+18.
    do_load(8'd12, 1'b0);
    @(negedge clk);
    do_load(8'd34, 1'b0);
    @(negedge clk);
    do_load(8'd56, 1'b0);
    count_busy(n);
    check("buf_busy_tail", 32'(n), 32'd14);
    @(negedge clk);
    capture_frame();
    check_frame("buf56", 7'b1011111, 7'b1011011, 7'b0000000, 7'b0000000);

    // Clear mid-conversion: load 200 at E, clear sampled at E+4.
    do_load(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    $display("clear pulse at cycle %0d", cyc);
    check("clr_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    capture_frame();
    check_frame("clr", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
